// File: rtl/barrel_shifter_pipe.sv
// Pipelined rotate/shift, one register stage per amount bit: latency AW cycles, one word per cycle.
// Global stall: every stage holds while y is valid and not taken; in_ready = ~out_valid | out_ready.
module barrel_shifter_pipe #(
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [AW-1:0]    amt,
    input  logic             lr,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y
);
    localparam int L = AW;

    logic [WIDTH-1:0] dat_q [L];
    logic [AW-1:0]    amt_q [L];
    logic             vld_q [L];
    logic             lr_q  [L];
    logic             rot_q [L];
    logic             ari_q [L];
    logic             sgn_q [L];

    logic [WIDTH-1:0] dat_d [L];
    logic [AW-1:0]    amt_d [L];
    logic             vld_d [L];
    logic             lr_d  [L];
    logic             rot_d [L];
    logic             ari_d [L];
    logic             sgn_d [L];

    logic advance;

    // One fixed-distance step; WIDTH is a power of two so the source index wraps for free.
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] d,
        input int               s,
        input logic             right,
        input logic             rot,
        input logic             fill
    );
        logic [WIDTH-1:0] r;
        logic [AW-1:0]    src;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (right) begin
                src  = AW'(i + s);
                r[i] = ((i + s) < WIDTH || rot) ? d[src] : fill;
            end else begin
                src  = AW'(i - s);
                r[i] = (i >= s || rot) ? d[src] : 1'b0;
            end
        end
        return r;
    endfunction

    assign advance   = ~out_valid | out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_q[L-1];
    assign y         = dat_q[L-1];

    // Reserved mode 11 decodes to neither rotate nor arithmetic, i.e. logical.
    always_comb begin
        dat_d[0] = a;
        amt_d[0] = amt;
        vld_d[0] = in_valid;
        lr_d[0]  = lr;
        rot_d[0] = (mode == 2'b00);
        ari_d[0] = (mode == 2'b10);
        sgn_d[0] = a[WIDTH-1];
        for (int k = 1; k < L; k++) begin
            dat_d[k] = dat_q[k-1];
            amt_d[k] = amt_q[k-1];
            vld_d[k] = vld_q[k-1];
            lr_d[k]  = lr_q[k-1];
            rot_d[k] = rot_q[k-1];
            ari_d[k] = ari_q[k-1];
            sgn_d[k] = sgn_q[k-1];
        end
    end

    // The amount is shifted down one bit per stage so each stage consumes bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < L; k++) begin
                dat_q[k] <= '0;
                amt_q[k] <= '0;
                vld_q[k] <= 1'b0;
                lr_q[k]  <= 1'b0;
                rot_q[k] <= 1'b0;
                ari_q[k] <= 1'b0;
                sgn_q[k] <= 1'b0;
            end
        end else if (advance) begin
            for (int k = 0; k < L; k++) begin
                dat_q[k] <= amt_d[k][0]
                          ? shift_step(dat_d[k], 1 << k, lr_d[k], rot_d[k], ari_d[k] & sgn_d[k])
                          : dat_d[k];
                amt_q[k] <= amt_d[k] >> 1;
                vld_q[k] <= vld_d[k];
                lr_q[k]  <= lr_d[k];
                rot_q[k] <= rot_d[k];
                ari_q[k] <= ari_d[k];
                sgn_q[k] <= sgn_d[k];
            end
        end
    end
endmodule
